// File: rtl/frame_compositor.sv
`default_nettype none
// frame_compositor: owns the locked-block board, overlays the falling piece and
// double-buffers the 10x20 display frame, swapping it atomically once per vsync.
module frame_compositor #(
  parameter logic [2:0] EMPTY_COLOR = 3'b000
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         vsync_in,
  input  logic [3:0]   piece_x,
  input  logic [4:0]   piece_y,
  input  logic [15:0]  piece_shape,
  input  logic [2:0]   piece_color,
  input  logic         piece_valid,
  input  logic         lock_req,
  output logic         ready,
  output logic         lock_done,
  output logic [2:0]   rows_cleared,
  output logic         overflow,
  output logic         frame_swap,
  output logic [599:0] frame_out
);

  localparam int COLS = 10;
  localparam int ROWS = 20;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COMPOSE = 3'd1,
    S_SWAP    = 3'd2,
    S_MERGE   = 3'd3,
    S_SCAN    = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t state, state_next;

  logic [2:0]   board [ROWS][COLS];  // board[y][x]
  logic [599:0] back_buf;
  logic         vsync_q;
  logic         pending;
  logic         tick;
  logic [3:0]   lat_x;
  logic [4:0]   lat_y;
  logic [15:0]  lat_shape;
  logic [2:0]   lat_color;
  logic         lat_valid;
  logic [3:0]   col;
  logic [4:0]   scan_row;
  logic [2:0]   clr_cnt;
  logic         row_full;

  // True when the 4x4 mask anchored at (px,py) covers board cell (x,y).
  function automatic logic covers(input int x, input int y, input logic [3:0] px,
                                  input logic [4:0] py, input logic [15:0] shape);
    int dx;
    int dy;
    logic [3:0] bit_idx;
    dx = x - int'(px);
    dy = y - int'(py);
    bit_idx = 4'((dy << 2) + dx);
    return (dx >= 0) && (dx < 4) && (dy >= 0) && (dy < 4) && shape[bit_idx];
  endfunction

  assign tick  = vsync_in & ~vsync_q;
  assign ready = (state == S_IDLE);

  always_comb begin
    row_full = 1'b1;
    for (int x = 0; x < COLS; x++) begin
      if (board[scan_row][x] == EMPTY_COLOR) row_full = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (lock_req)     state_next = S_MERGE;
        else if (pending) state_next = S_COMPOSE;
      end
      S_COMPOSE: if (col == 4'd9) state_next = S_SWAP;
      S_SWAP:    state_next = S_IDLE;
      S_MERGE:   state_next = S_SCAN;
      S_SCAN:    if (!row_full && scan_row == 5'd0) state_next = S_DONE;
      S_DONE:    state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int y = 0; y < ROWS; y++)
        for (int x = 0; x < COLS; x++)
          board[y][x] <= EMPTY_COLOR;
      back_buf     <= {200{EMPTY_COLOR}};
      frame_out    <= {200{EMPTY_COLOR}};
      vsync_q      <= 1'b0;
      pending      <= 1'b0;
      lat_x        <= '0;
      lat_y        <= '0;
      lat_shape    <= '0;
      lat_color    <= '0;
      lat_valid    <= 1'b0;
      col          <= '0;
      scan_row     <= '0;
      clr_cnt      <= '0;
      lock_done    <= 1'b0;
      rows_cleared <= '0;
      overflow     <= 1'b0;
      frame_swap   <= 1'b0;
    end else begin
      vsync_q    <= vsync_in;
      lock_done  <= 1'b0;
      frame_swap <= 1'b0;

      // A new tick in the same cycle as the compose start must not be lost.
      if (state == S_IDLE && !lock_req && pending) pending <= 1'b0;
      if (tick) pending <= 1'b1;

      case (state)
        S_IDLE: begin
          if (lock_req || pending) begin
            lat_x     <= piece_x;
            lat_y     <= piece_y;
            lat_shape <= piece_shape;
            lat_color <= piece_color;
            lat_valid <= piece_valid;
            col       <= 4'd0;
          end
        end
        S_COMPOSE: begin
          for (int x = 0; x < COLS; x++) begin
            if (col == 4'(x)) begin
              for (int y = 0; y < ROWS; y++) begin
                back_buf[(x*ROWS+y)*3 +: 3] <=
                  (lat_valid && covers(x, y, lat_x, lat_y, lat_shape)) ? lat_color : board[y][x];
              end
            end
          end
          col <= col + 4'd1;
        end
        S_SWAP: begin
          frame_out  <= back_buf;
          frame_swap <= 1'b1;
        end
        S_MERGE: begin
          for (int y = 0; y < ROWS; y++) begin
            for (int x = 0; x < COLS; x++) begin
              if (covers(x, y, lat_x, lat_y, lat_shape)) begin
                if (board[y][x] != EMPTY_COLOR) overflow <= 1'b1;
                board[y][x] <= lat_color;
              end
            end
          end
          scan_row <= 5'd19;
          clr_cnt  <= 3'd0;
        end
        S_SCAN: begin
          if (row_full) begin
            // Drop everything above the full row by one; same row is rechecked.
            for (int r = 1; r < ROWS; r++) begin
              if (r <= int'(scan_row)) begin
                for (int x = 0; x < COLS; x++) board[r][x] <= board[r-1][x];
              end
            end
            for (int x = 0; x < COLS; x++) board[0][x] <= EMPTY_COLOR;
            if (clr_cnt != 3'd7) clr_cnt <= clr_cnt + 3'd1;
          end else if (scan_row != 5'd0) begin
            scan_row <= scan_row - 5'd1;
          end
        end
        S_DONE: begin
          lock_done    <= 1'b1;
          rows_cleared <= clr_cnt;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_frame_compositor.sv
`default_nettype none
// Randomised self-checking bench for frame_compositor against a cell-level board model.
module tb_frame_compositor;

  logic         clock = 1'b0;
  logic         reset;
  logic         vsync_in;
  logic [3:0]   piece_x;
  logic [4:0]   piece_y;
  logic [15:0]  piece_shape;
  logic [2:0]   piece_color;
  logic         piece_valid;
  logic         lock_req;
  logic         ready;
  logic         lock_done;
  logic [2:0]   rows_cleared;
  logic         overflow;
  logic         frame_swap;
  logic [599:0] frame_out;

  int n_checks = 0;
  int n_pass   = 0;

  logic [2:0] mb [10][20];  // model board, mb[x][y]
  bit         m_ovf;

  frame_compositor dut (
    .clock        (clock),
    .reset        (reset),
    .vsync_in     (vsync_in),
    .piece_x      (piece_x),
    .piece_y      (piece_y),
    .piece_shape  (piece_shape),
    .piece_color  (piece_color),
    .piece_valid  (piece_valid),
    .lock_req     (lock_req),
    .ready        (ready),
    .lock_done    (lock_done),
    .rows_cleared (rows_cleared),
    .overflow     (overflow),
    .frame_swap   (frame_swap),
    .frame_out    (frame_out)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [599:0] got, input logic [599:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic void model_clear();
    for (int x = 0; x < 10; x++)
      for (int y = 0; y < 20; y++)
        mb[x][y] = 3'b000;
    m_ovf = 1'b0;
  endfunction

  function automatic logic [599:0] model_frame(input int px, input int py, input logic [15:0] sh,
                                               input logic [2:0] c, input bit v);
    logic [599:0] f;
    f = '0;
    for (int x = 0; x < 10; x++)
      for (int y = 0; y < 20; y++)
        f[(x*20+y)*3 +: 3] = mb[x][y];
    if (v) begin
      for (int r = 0; r < 4; r++)
        for (int q = 0; q < 4; q++)
          if (sh[4'(r*4+q)] && px + q < 10 && py + r < 20)
            f[((px+q)*20 + py + r)*3 +: 3] = c;
    end
    return f;
  endfunction

  // Merge then remove every full row, compacting the survivors to the bottom.
  function automatic int model_lock(input int px, input int py, input logic [15:0] sh,
                                    input logic [2:0] c);
    logic [2:0] nb [10][20];
    int dst;
    int cleared;
    bit full;
    for (int r = 0; r < 4; r++)
      for (int q = 0; q < 4; q++)
        if (sh[4'(r*4+q)] && px + q < 10 && py + r < 20) begin
          if (mb[px+q][py+r] != 3'b000) m_ovf = 1'b1;
          mb[px+q][py+r] = c;
        end
    for (int x = 0; x < 10; x++)
      for (int y = 0; y < 20; y++)
        nb[x][y] = 3'b000;
    dst = 19;
    cleared = 0;
    for (int y = 19; y >= 0; y--) begin
      full = 1'b1;
      for (int x = 0; x < 10; x++) if (mb[x][y] == 3'b000) full = 1'b0;
      if (full) cleared++;
      else begin
        for (int x = 0; x < 10; x++) nb[x][dst] = mb[x][y];
        dst--;
      end
    end
    for (int x = 0; x < 10; x++)
      for (int y = 0; y < 20; y++)
        mb[x][y] = nb[x][y];
    return (cleared > 7) ? 7 : cleared;
  endfunction

  task automatic set_piece(input int px, input int py, input logic [15:0] sh,
                           input logic [2:0] c, input bit v);
    piece_x     = 4'(px);
    piece_y     = 5'(py);
    piece_shape = sh;
    piece_color = c;
    piece_valid = v;
  endtask

  task automatic do_frame(input int px, input int py, input logic [15:0] sh,
                          input logic [2:0] c, input bit v);
    bit got;
    int lat;
    set_piece(px, py, sh, c, v);
    vsync_in = 1'b1;
    got = 1'b0;
    lat = -1;
    // lat counts clock edges after the one that samples the vsync rise
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (i == 2) vsync_in = 1'b0;
      if (frame_swap) begin
        got = 1'b1;
        lat = i;
        break;
      end
    end
    check("swap_seen", got, 1'b1);
    check("swap_latency", lat, 12);
    check("frame", frame_out, model_frame(px, py, sh, c, v));
    @(negedge clock);
    check("swap_pulse_width", frame_swap, 1'b0);
  endtask

  task automatic do_lock(input int px, input int py, input logic [15:0] sh,
                         input logic [2:0] c, input bit vs_mid);
    int exp_clr;
    bit done;
    bit early;
    set_piece(px, py, sh, c, 1'b0);
    check("ready_before_lock", ready, 1'b1);
    lock_req = 1'b1;
    @(negedge clock);
    lock_req = 1'b0;
    exp_clr = model_lock(px, py, sh, c);
    done  = 1'b0;
    early = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (vs_mid && i == 4) vsync_in = 1'b1;
      if (vs_mid && i == 6) vsync_in = 1'b0;
      @(negedge clock);
      if (frame_swap) early = 1'b1;
      if (lock_done) begin
        done = 1'b1;
        break;
      end
    end
    check("lock_done_seen", done, 1'b1);
    check("rows_cleared", rows_cleared, exp_clr);
    check("overflow", overflow, m_ovf);
    if (vs_mid) check("no_swap_before_done", early, 1'b0);
  endtask

  task automatic wait_swap(input logic [599:0] exp);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (frame_swap) begin
        got = 1'b1;
        break;
      end
    end
    check("deferred_swap_seen", got, 1'b1);
    check("deferred_frame", frame_out, exp);
  endtask

  initial begin
    reset    = 1'b1;
    vsync_in = 1'b0;
    lock_req = 1'b0;
    set_piece(0, 0, 16'h0000, 3'b000, 1'b0);
    model_clear();
    repeat (3) @(negedge clock);
    check("reset_frame", frame_out, '0);
    check("reset_ready", ready, 1'b1);
    check("reset_lock_done", lock_done, 1'b0);
    check("reset_rows_cleared", rows_cleared, 3'd0);
    check("reset_overflow", overflow, 1'b0);
    check("reset_frame_swap", frame_swap, 1'b0);
    reset = 1'b0;
    @(negedge clock);

    do_frame(0, 0, 16'h0000, 3'b000, 1'b0);
    do_frame(3, 0, 16'h000F, 3'b100, 1'b1);
    do_frame(0, 0, 16'h0000, 3'b000, 1'b0);

    // Build row 19 at x=0..5,9 plus a marker in row 18, then complete it.
    do_lock(0, 19, 16'h000F, 3'd1, 1'b0);
    do_lock(4, 19, 16'h0003, 3'd2, 1'b0);
    do_lock(9, 19, 16'h0001, 3'd3, 1'b0);
    do_lock(0, 18, 16'h0001, 3'd5, 1'b0);
    do_lock(6, 19, 16'h0007, 3'd6, 1'b0);
    do_frame(0, 0, 16'h0000, 3'b000, 1'b0);

    // Complete row 19 again, with a vsync rise landing during the row scan.
    do_lock(1, 19, 16'h000F, 3'd1, 1'b0);
    do_lock(5, 19, 16'h000F, 3'd2, 1'b0);
    do_lock(9, 19, 16'h0001, 3'd3, 1'b1);
    wait_swap(model_frame(9, 19, 16'h0001, 3'd3, 1'b0));

    do_lock(2, 5, 16'h0033, 3'd4, 1'b0);
    do_lock(2, 5, 16'h0033, 3'd4, 1'b0);
    do_frame(8, 3, 16'h000F, 3'd7, 1'b1);

    for (int k = 0; k < 24; k++) begin
      int px, py;
      logic [15:0] sh;
      px = int'($urandom_range(0, 15));
      py = int'($urandom_range(0, 31));
      sh = 16'($urandom);
      if ($urandom_range(0, 1) == 0)
        do_lock(px, py, sh, 3'($urandom_range(1, 7)), 1'b0);
      else
        do_frame(px, py, sh, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    end

    // Reset while a compose is in progress.
    set_piece(8, 0, 16'h000F, 3'd5, 1'b1);
    vsync_in = 1'b1;
    repeat (2) @(negedge clock);
    vsync_in = 1'b0;
    repeat (4) @(negedge clock);
    reset = 1'b1;
    model_clear();
    @(negedge clock);
    check("midreset_frame", frame_out, '0);
    check("midreset_ready", ready, 1'b1);
    check("midreset_overflow", overflow, 1'b0);
    check("midreset_rows_cleared", rows_cleared, 3'd0);
    reset = 1'b0;
    repeat (20) @(negedge clock);
    check("midreset_no_swap", frame_out, '0);
    do_frame(0, 0, 16'h0000, 3'b000, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
